// File: rtl/turf_acknack_arbiter_pkg.sv
// turf_acknack_arbiter_pkg: shared types and widths for the ack/nack response arbiter.
//   acknack_t    : frame-buffer acknack beat, [15]=allow, [11:0]=addr
//   udphdr_t     : UDP response header {ip, port, length}
//   resp_state_e : response-path FSM states
package turf_acknack_arbiter_pkg;
    localparam int HDR_W  = 64;
    localparam int DATA_W = 64;
    localparam int KEEP_W = 8;
    localparam int AK_W   = 16;
    typedef struct packed {
        logic        allow;
        logic [2:0]  rsvd;
        logic [11:0] addr;
    } acknack_t;
    typedef struct packed {
        logic [31:0] ip;
        logic [15:0] port;
        logic [15:0] length;
    } udphdr_t;
    typedef enum logic [1:0] {RESP_IDLE, RESP_HDR, RESP_DATA} resp_state_e;
endpackage

// File: rtl/turf_acknack_arbiter_if.sv
// turf_acknack_arbiter_if: per-port ack/nack upstream streams plus merged UDP/acknack outputs.
//   s_udphdr_* / s_udpdata_* / s_acknack_* : NUM_PORTS-wide upstream channels
//   m_udphdr_* / m_udpdata_* / m_acknack_* : single merged downstream channels
//   modport slave  : the arbiter's view
//   modport master : the surrounding handlers / UDP TX / frame buffer view
interface turf_acknack_arbiter_if import turf_acknack_arbiter_pkg::*; #(parameter int NUM_PORTS = 2);
    logic [HDR_W*NUM_PORTS-1:0]  s_udphdr_tdata;
    logic [NUM_PORTS-1:0]        s_udphdr_tvalid, s_udphdr_tready;
    logic [DATA_W*NUM_PORTS-1:0] s_udpdata_tdata;
    logic [KEEP_W*NUM_PORTS-1:0] s_udpdata_tkeep;
    logic [NUM_PORTS-1:0]        s_udpdata_tlast, s_udpdata_tvalid, s_udpdata_tready;
    logic [AK_W*NUM_PORTS-1:0]   s_acknack_tdata;
    logic [NUM_PORTS-1:0]        s_acknack_tvalid, s_acknack_tready;
    logic [HDR_W-1:0]            m_udphdr_tdata;
    logic                        m_udphdr_tvalid, m_udphdr_tready;
    logic [DATA_W-1:0]           m_udpdata_tdata;
    logic [KEEP_W-1:0]           m_udpdata_tkeep;
    logic                        m_udpdata_tlast, m_udpdata_tvalid, m_udpdata_tready;
    logic [AK_W-1:0]             m_acknack_tdata;
    logic                        m_acknack_tvalid, m_acknack_tready;
    modport slave (
        input  s_udphdr_tdata, s_udphdr_tvalid, output s_udphdr_tready,
        input  s_udpdata_tdata, s_udpdata_tkeep, s_udpdata_tlast, s_udpdata_tvalid, output s_udpdata_tready,
        input  s_acknack_tdata, s_acknack_tvalid, output s_acknack_tready,
        output m_udphdr_tdata, m_udphdr_tvalid, input m_udphdr_tready,
        output m_udpdata_tdata, m_udpdata_tkeep, m_udpdata_tlast, m_udpdata_tvalid, input m_udpdata_tready,
        output m_acknack_tdata, m_acknack_tvalid, input m_acknack_tready
    );
    modport master (
        output s_udphdr_tdata, s_udphdr_tvalid, input s_udphdr_tready,
        output s_udpdata_tdata, s_udpdata_tkeep, s_udpdata_tlast, s_udpdata_tvalid, input s_udpdata_tready,
        output s_acknack_tdata, s_acknack_tvalid, input s_acknack_tready,
        input  m_udphdr_tdata, m_udphdr_tvalid, output m_udphdr_tready,
        input  m_udpdata_tdata, m_udpdata_tkeep, m_udpdata_tlast, m_udpdata_tvalid, output m_udpdata_tready,
        input  m_acknack_tdata, m_acknack_tvalid, output m_acknack_tready
    );
endinterface

// File: rtl/turf_acknack_arbiter_rr.sv
// turf_rr_arbiter: round-robin pick of the first requester at or after the pointer.
//   aclk, areset : clock, async active-high reset (pointer -> 0)
//   req_i        : request vector
//   adv_i, win_i : on adv_i the pointer moves to win_i+1 (wrapping)
//   gnt_o, idx_o : one-hot grant and its encoded index (combinational)
module turf_rr_arbiter #(
    parameter  int N  = 2,
    localparam int PW = $clog2(N)
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic [N-1:0]  req_i,
    input  logic          adv_i,
    input  logic [PW-1:0] win_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o
);
    logic [PW-1:0] ptr_q;
    int j;
    // Scanning from the far end lets the nearest requester overwrite earlier hits.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        j = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr_q) + k) % N;
            if (req_i[j]) begin
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
                idx_o    = PW'(j);
            end
        end
    end
    always_ff @(posedge aclk or posedge areset)
        if (areset) ptr_q <= '0;
        else if (adv_i) ptr_q <= (win_i == PW'(N - 1)) ? '0 : win_i + 1'b1;
endmodule

// File: rtl/turf_acknack_arbiter.sv
// turf_acknack_arbiter: shares the UDP response path (packet-locked) and the frame-buffer
// acknack stream (per-beat round-robin, one register stage) between NUM_PORTS ports.
//   aclk, areset  : clock, async active-high reset
//   bus           : upstream per-port and merged downstream streams (slave modport)
//   resp_grant_o  : port owning the response path
module turf_acknack_arbiter import turf_acknack_arbiter_pkg::*; #(
    parameter  int NUM_PORTS = 2,
    localparam int PTR_BITS  = $clog2(NUM_PORTS)
) (
    input  logic                  aclk,
    input  logic                  areset,
    turf_acknack_arbiter_if.slave bus,
    output logic [PTR_BITS-1:0]   resp_grant_o
);
    resp_state_e          state_q;
    logic [PTR_BITS-1:0]  grant_q, rsp_idx, ak_idx;
    logic [NUM_PORTS-1:0] rsp_gnt, ak_gnt, grant_oh;
    logic                 hdr_hs, data_hs, ak_en, ak_valid_q;
    acknack_t             ak_data_q;

    turf_rr_arbiter #(.N(NUM_PORTS)) u_rsp_rr (
        .aclk(aclk), .areset(areset), .req_i(bus.s_udphdr_tvalid),
        .adv_i(data_hs && bus.m_udpdata_tlast), .win_i(grant_q),
        .gnt_o(rsp_gnt), .idx_o(rsp_idx)
    );
    turf_rr_arbiter #(.N(NUM_PORTS)) u_ak_rr (
        .aclk(aclk), .areset(areset), .req_i(bus.s_acknack_tvalid),
        .adv_i(ak_en && |ak_gnt), .win_i(ak_idx),
        .gnt_o(ak_gnt), .idx_o(ak_idx)
    );

    assign grant_oh     = NUM_PORTS'(1) << grant_q;
    assign resp_grant_o = grant_q;

    assign bus.m_udphdr_tdata   = bus.s_udphdr_tdata[grant_q*HDR_W +: HDR_W];
    assign bus.m_udphdr_tvalid  = state_q == RESP_HDR && bus.s_udphdr_tvalid[grant_q];
    assign bus.s_udphdr_tready  = (state_q == RESP_HDR && bus.m_udphdr_tready) ? grant_oh : '0;
    assign bus.m_udpdata_tdata  = bus.s_udpdata_tdata[grant_q*DATA_W +: DATA_W];
    assign bus.m_udpdata_tkeep  = bus.s_udpdata_tkeep[grant_q*KEEP_W +: KEEP_W];
    assign bus.m_udpdata_tlast  = bus.s_udpdata_tlast[grant_q];
    assign bus.m_udpdata_tvalid = state_q == RESP_DATA && bus.s_udpdata_tvalid[grant_q];
    assign bus.s_udpdata_tready = (state_q == RESP_DATA && bus.m_udpdata_tready) ? grant_oh : '0;
    assign hdr_hs  = bus.m_udphdr_tvalid && bus.m_udphdr_tready;
    assign data_hs = bus.m_udpdata_tvalid && bus.m_udpdata_tready;

    always_ff @(posedge aclk or posedge areset)
        if (areset) begin
            state_q <= RESP_IDLE;
            grant_q <= '0;
        end else
            case (state_q)
                RESP_IDLE: if (|rsp_gnt) begin
                    grant_q <= rsp_idx;
                    state_q <= RESP_HDR;
                end
                RESP_HDR:  if (hdr_hs) state_q <= RESP_DATA;
                RESP_DATA: if (data_hs && bus.m_udpdata_tlast) state_q <= RESP_IDLE;
                default:   state_q <= RESP_IDLE;
            endcase

    // The register accepts a new beat whenever it is empty or draining this cycle;
    // the reset term keeps tready low while areset is held with an empty register.
    assign ak_en                = !ak_valid_q || bus.m_acknack_tready;
    assign bus.s_acknack_tready = (ak_en && !areset) ? ak_gnt : '0;
    assign bus.m_acknack_tvalid = ak_valid_q;
    assign bus.m_acknack_tdata  = ak_data_q;

    always_ff @(posedge aclk or posedge areset)
        if (areset) begin
            ak_valid_q <= 1'b0;
            ak_data_q  <= '0;
        end else if (ak_en) begin
            ak_valid_q <= |ak_gnt;
            if (|ak_gnt) ak_data_q <= acknack_t'(bus.s_acknack_tdata[ak_idx*AK_W +: AK_W]);
        end
endmodule
